// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and
// redirect handling with a sticky fault on misaligned targets.
module fetch_stage #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR =
        DATA_WIDTH'(32'h0040_0000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic                  IF_ID_Valid_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_Plus_4_o,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
    output logic                  Misaligned_o,
    output logic [DATA_WIDTH-1:0] Fault_Addr_o,
    output logic [31:0]           Fetch_Count_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_if_pc;
    logic [DATA_WIDTH-1:0] r_if_pc4;
    logic [DATA_WIDTH-1:0] r_if_instr;
    logic                  r_misaligned;
    logic [DATA_WIDTH-1:0] r_fault_addr;
    logic [31:0]           r_count;

    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] w_if_pc_nxt;
    logic [DATA_WIDTH-1:0] w_if_pc4_nxt;
    logic [DATA_WIDTH-1:0] w_if_instr_nxt;
    logic                  w_misaligned_nxt;
    logic [DATA_WIDTH-1:0] w_fault_addr_nxt;
    logic [31:0]           w_count_nxt;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_aligned;

    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
    assign w_aligned  = (Target_i[1:0] == 2'b00);

    // State register; reset always returns to BOOT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update selection (redirect > stall > advance).
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;
        w_if_pc_nxt      = r_if_pc;
        w_if_pc4_nxt     = r_if_pc4;
        w_if_instr_nxt   = r_if_instr;
        w_misaligned_nxt = r_misaligned;
        w_fault_addr_nxt = r_fault_addr;
        w_count_nxt      = r_count;
        unique case (r_state)
            ST_BOOT: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (Redirect_i) begin
                    w_valid_nxt = 1'b0;
                    if (w_aligned) begin
                        w_pc_nxt = Target_i;
                    end else begin
                        w_misaligned_nxt = 1'b1;
                        w_fault_addr_nxt = Target_i;
                        w_state_nxt      = ST_HALT;
                    end
                end else if (!Stall_i) begin
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc_plus4;
                    w_if_instr_nxt = Instruction_i;
                    w_valid_nxt    = 1'b1;
                    w_pc_nxt       = w_pc_plus4;
                    w_count_nxt    = r_count + 32'd1;
                end
            end
            ST_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // PC, IF/ID latch, fault capture and fetch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_VECTOR;
            r_valid      <= 1'b0;
            r_if_pc      <= '0;
            r_if_pc4     <= '0;
            r_if_instr   <= '0;
            r_misaligned <= 1'b0;
            r_fault_addr <= '0;
            r_count      <= '0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_pc4     <= w_if_pc4_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_fault_addr <= w_fault_addr_nxt;
            r_count      <= w_count_nxt;
        end
    end

    assign PC_o                = r_pc;
    assign IF_ID_Valid_o       = r_valid;
    assign IF_ID_PC_o          = r_if_pc;
    assign IF_ID_PC_Plus_4_o   = r_if_pc4;
    assign IF_ID_Instruction_o = r_if_instr;
    assign Misaligned_o        = r_misaligned;
    assign Fault_Addr_o        = r_fault_addr;
    assign Fetch_Count_o       = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus
// randomized stall/redirect traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc_o;
    logic        v_o;
    logic [31:0] ifpc_o;
    logic [31:0] ifpc4_o;
    logic [31:0] ifins_o;
    logic        mis_o;
    logic [31:0] fa_o;
    logic [31:0] cnt_o;

    logic        reset2;
    logic [31:0] pc2;
    logic        v2;
    logic [31:0] ifpc2;
    logic [31:0] ifpc42;
    logic [31:0] ifins2;
    logic        mis2;
    logic [31:0] fa2;
    logic [31:0] cnt2;

    int n_chk;
    int n_fail;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return ((a - RV) >> 2) + 32'h0000_1000;
    endfunction

    assign instr = mem(pc_o);

    fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall_i             (stall),
        .Redirect_i          (redirect),
        .Target_i            (target),
        .Instruction_i       (instr),
        .PC_o                (pc_o),
        .IF_ID_Valid_o       (v_o),
        .IF_ID_PC_o          (ifpc_o),
        .IF_ID_PC_Plus_4_o   (ifpc4_o),
        .IF_ID_Instruction_o (ifins_o),
        .Misaligned_o        (mis_o),
        .Fault_Addr_o        (fa_o),
        .Fetch_Count_o       (cnt_o)
    );

    fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
        .clk                 (clk),
        .reset               (reset2),
        .Stall_i             (1'b0),
        .Redirect_i          (1'b0),
        .Target_i            (32'h0),
        .Instruction_i       (32'h0000_0013),
        .PC_o                (pc2),
        .IF_ID_Valid_o       (v2),
        .IF_ID_PC_o          (ifpc2),
        .IF_ID_PC_Plus_4_o   (ifpc42),
        .IF_ID_Instruction_o (ifins2),
        .Misaligned_o        (mis2),
        .Fault_Addr_o        (fa2),
        .Fetch_Count_o       (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one fetch slot per cycle, boot delay, halt.
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_ins, m_fa, m_cnt;
    logic        m_v, m_mis;
    bit          m_boot, m_halt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_boot = 1; m_halt = 0;
            m_pc = RV; m_v = 0; m_ifpc = 0; m_ifpc4 = 0;
            m_ins = 0; m_mis = 0; m_fa = 0; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            m_v = 0;
        end else if (redirect) begin
            m_v = 0;
            if (target % 4 == 0) begin
                m_pc = target;
            end else begin
                m_mis = 1; m_fa = target; m_halt = 1;
            end
        end else if (!stall) begin
            m_ifpc = m_pc;
            m_ifpc4 = m_pc + 4;
            m_ins = mem(m_pc);
            m_v = 1;
            m_pc = m_pc + 4;
            m_cnt = m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("pc", pc_o, m_pc);
        chk("valid", {31'b0, v_o}, {31'b0, m_v});
        chk("if_pc", ifpc_o, m_ifpc);
        chk("if_pc4", ifpc4_o, m_ifpc4);
        chk("if_ins", ifins_o, m_ins);
        chk("mis", {31'b0, mis_o}, {31'b0, m_mis});
        chk("fault", fa_o, m_fa);
        chk("count", cnt_o, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_pc"}, pc_o, RV);
        chk({nm, "_v"}, {31'b0, v_o}, 32'd0);
        chk({nm, "_ifpc"}, ifpc_o, 32'd0);
        chk({nm, "_ifpc4"}, ifpc4_o, 32'd0);
        chk({nm, "_ins"}, ifins_o, 32'd0);
        chk({nm, "_mis"}, {31'b0, mis_o}, 32'd0);
        chk({nm, "_fa"}, fa_o, 32'd0);
        chk({nm, "_cnt"}, cnt_o, 32'd0);
    endtask

    int r;

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 0; reset2 = 0;
        stall = 0; redirect = 0; target = 0;
        repeat (3) step();
        chk_reset_vals("rst");
        reset = 1; reset2 = 1;
        step();
        chk("boot_pc", pc_o, 32'h0040_0000);
        chk("boot_v", {31'b0, v_o}, 32'd0);
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        step();
        chk("seq1_pc", pc_o, 32'h0040_0004);
        chk("seq1_ifpc", ifpc_o, 32'h0040_0000);
        chk("seq1_ins", ifins_o, 32'h0000_1000);
        chk("seq1_cnt", cnt_o, 32'd1);
        chk("seq1_v", {31'b0, v_o}, 32'd1);
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        step();
        chk("seq2_pc", pc_o, 32'h0040_0008);
        chk("seq2_ins", ifins_o, 32'h0000_1001);
        chk("seq2_cnt", cnt_o, 32'd2);
        chk("wrap_pc2", pc2, 32'h0000_0000);
        chk("wrap_pc4", ifpc42, 32'h0000_0000);
        chk("wrap_mis", {31'b0, mis2}, 32'd0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_o, 32'h0040_0008);
            chk("stall_ifpc", ifpc_o, 32'h0040_0004);
            chk("stall_cnt", cnt_o, 32'd2);
        end
        stall = 0;
        step();
        chk("resume_pc", pc_o, 32'h0040_000C);
        chk("resume_ifpc", ifpc_o, 32'h0040_0008);
        chk("resume_cnt", cnt_o, 32'd3);
        redirect = 1; stall = 1; target = 32'h0040_0100;
        step();
        chk("redir_pc", pc_o, 32'h0040_0100);
        chk("redir_v", {31'b0, v_o}, 32'd0);
        chk("redir_cnt", cnt_o, 32'd3);
        redirect = 0; stall = 0;
        step();
        chk("redir2_ifpc", ifpc_o, 32'h0040_0100);
        chk("redir2_v", {31'b0, v_o}, 32'd1);
        redirect = 1; target = 32'h0040_0102;
        step();
        chk("mis_flag", {31'b0, mis_o}, 32'd1);
        chk("mis_fa", fa_o, 32'h0040_0102);
        chk("mis_pc", pc_o, 32'h0040_0104);
        chk("mis_v", {31'b0, v_o}, 32'd0);
        target = 32'h0040_0200;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt_pc", pc_o, 32'h0040_0104);
            chk("halt_fa", fa_o, 32'h0040_0102);
            chk("halt_mis", {31'b0, mis_o}, 32'd1);
        end
        redirect = 0;
        reset = 0;
        step();
        reset = 1;
        step();
        stall = 1;
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        chk_reset_vals("async");
        step();
        reset = 1; stall = 0;
        step();
        chk("reboot_pc", pc_o, 32'h0040_0000);
        chk("reboot_v", {31'b0, v_o}, 32'd0);
        step();
        chk("reboot_pc2", pc_o, 32'h0040_0004);
        chk("reboot_cnt", cnt_o, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step();
            r = $urandom_range(0, 99);
            redirect = (r < 10);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0)
                target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            else
                target = RV + 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 24) == 0)
                target = target + 32'($urandom_range(1, 3));
            if ((m_halt && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 299) == 0) begin
                #($urandom_range(0, 3));
                reset = 0;
                step();
                reset = 1;
            end
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of PC, target and instruction words.
REQ-002 Parameter RESET_VECTOR, default 32'h0040_0000, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 Stall_i  input  1  hazard stall from decode; hold PC and IF/ID register.
REQ-006 Redirect_i  input  1  taken branch/jump; load Target_i into PC, flush IF/ID.
REQ-007 Target_i  input  DATA_WIDTH  redirect target byte address.
REQ-008 Instruction_i  input  DATA_WIDTH  instruction word returned combinationally by program memory for PC_o.
REQ-009 PC_o  output  DATA_WIDTH  current fetch byte address, drives program memory Address_i.
REQ-010 IF_ID_Valid_o  output  1  IF/ID register holds a real instruction.
REQ-011 IF_ID_PC_o  output  DATA_WIDTH  PC of latched instruction.
REQ-012 IF_ID_PC_Plus_4_o  output  DATA_WIDTH  PC+4 of latched instruction.
REQ-013 IF_ID_Instruction_o  output  DATA_WIDTH  latched instruction word.
REQ-014 Misaligned_o  output  1  sticky fault: redirect target not word aligned.
REQ-015 Fault_Addr_o  output  DATA_WIDTH  offending target captured on fault.
REQ-016 Fetch_Count_o  output  32  count of instructions latched valid into IF/ID.

Function
REQ-017 FSM states SHALL be BOOT, RUN, HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one cycle after reset release: PC held, IF_ID_Valid_o=0, then RUN unconditionally (Stall_i/Redirect_i ignored in BOOT).
REQ-019 RUN priority SHALL be Redirect_i > Stall_i > sequential advance.
REQ-020 RUN, Redirect_i=1, Target_i[1:0]=2'b00: PC<=Target_i; IF_ID_Valid_o<=0; other IF/ID fields hold; Fetch_Count_o holds; redirect honored even when Stall_i=1.
REQ-021 RUN, Redirect_i=1, Target_i[1:0]!=0: PC holds; IF_ID_Valid_o<=0; Misaligned_o<=1; Fault_Addr_o<=Target_i; next state HALT.
REQ-022 RUN, Stall_i=1, Redirect_i=0: PC, all IF/ID fields, Fetch_Count_o hold.
REQ-023 RUN, no stall/redirect: IF_ID_PC_o<=PC_o; IF_ID_PC_Plus_4_o<=PC_o+4; IF_ID_Instruction_o<=Instruction_i; IF_ID_Valid_o<=1; PC<=PC_o+4; Fetch_Count_o<=Fetch_Count_o+1.
REQ-024 PC+4 SHALL wrap modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no fault.
REQ-025 Fetch_Count_o SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-026 HALT SHALL hold PC, keep IF_ID_Valid_o=0, Misaligned_o=1, Fault_Addr_o stable, ignore all inputs until reset.
REQ-027 PC_o SHALL be the PC register directly (no combinational path from Stall_i/Redirect_i/Target_i); instruction for PC_o latched same edge PC advances (one-cycle fetch latency).
REQ-028 Only one fault captured; Fault_Addr_o never updates outside the RUN->HALT transition.

Reset
REQ-029 While reset=0 (asynchronously on assertion): state=BOOT, PC_o=RESET_VECTOR, IF_ID_Valid_o=0, IF_ID_PC_o=0, IF_ID_PC_Plus_4_o=0, IF_ID_Instruction_o=0, Misaligned_o=0, Fault_Addr_o=0, Fetch_Count_o=0.
REQ-030 Reset asserted mid-operation (any state, incl. HALT or during stall) SHALL abort immediately with values of REQ-029; no partial update on the deasserting edge.

Verification
REQ-031 Reset release, no stall, memory returns word i at addr 0x0040_0000+4i -> BOOT 1 cycle; then PC_o 0x00400000, 0x00400004, 0x00400008; IF_ID_PC_o trails PC_o by one cycle with matching instruction; Fetch_Count_o 1,2,3.
REQ-032 Stall_i=1 for 3 cycles at PC 0x00400008 -> PC_o, IF/ID fields, Fetch_Count_o constant 3 cycles; resume at 0x0040000C.
REQ-033 Redirect_i=1, Stall_i=1, Target_i=0x00400100 -> next cycle PC_o=0x00400100, IF_ID_Valid_o=0; following cycle IF_ID_PC_o=0x00400100, valid=1.
REQ-034 Redirect_i=1, Target_i=0x00400102 -> Misaligned_o=1, Fault_Addr_o=0x00400102, PC_o held, valid=0; later redirect to 0x00400200 ignored; only reset clears.
REQ-035 RESET_VECTOR=32'hFFFF_FFF8, run 3 cycles -> PC_o 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; no fault.
REQ-036 Assert reset between clock edges during stall -> outputs take REQ-029 values before next edge; after release BOOT repeats.
